// File: rtl/npc_pkg.sv
// Shared definitions for the NPC next-PC sequencer: branch codes, the
// sequencer state enum and the default reset PC.
package npc_pkg;

  // Branch codes reported by the execute stage
  localparam logic [2:0] BR_NONE    = 3'b000;
  localparam logic [2:0] BR_JAL     = 3'b001;
  localparam logic [2:0] BR_JALR    = 3'b010;
  localparam logic [2:0] BR_ILLEGAL = 3'b011;
  localparam logic [2:0] BR_EQ      = 3'b100;
  localparam logic [2:0] BR_NE      = 3'b101;
  localparam logic [2:0] BR_LT      = 3'b110;
  localparam logic [2:0] BR_GE      = 3'b111;

  // Default program counter after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_FETCH     = 2'b00,
    ST_WAIT_INST = 2'b01,
    ST_EXEC      = 2'b10,
    ST_HALT      = 2'b11
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch request / instruction return handshake between the sequencer
// (master) and the instruction fetch unit (slave).
interface pc_sequencer_if;

  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output fetch_valid,
    output fetch_addr,
    output inst_ready,
    input  fetch_ready,
    input  inst_valid
  );

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    input  inst_ready,
    output fetch_ready,
    output inst_valid
  );

endinterface

// File: rtl/pc_sequencer_branch_resolve.sv
// Combinational next-PC resolution: decodes the 3-bit branch code against
// the ALU flags and produces the next PC plus taken/illegal qualifiers.
import npc_pkg::*;

module branch_resolve (
  input  logic [2:0]  branch,
  input  logic        less,
  input  logic        zero,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] next_pc,
  output logic        taken,
  output logic        illegal
);

  logic [31:0] seq_pc_s;
  logic [31:0] rel_pc_s;
  logic [31:0] reg_pc_s;

  assign seq_pc_s = pc + 32'd4;
  assign rel_pc_s = pc + imm;
  // jalr clears bit 0 of the computed target
  assign reg_pc_s = (rs1 + imm) & ~32'h1;

  // Select next PC and qualifiers from the branch code
  always_comb begin
    next_pc = seq_pc_s;
    taken   = 1'b0;
    illegal = 1'b0;
    case (branch)
      BR_NONE: begin
        next_pc = seq_pc_s;
      end
      BR_JAL: begin
        next_pc = rel_pc_s;
        taken   = 1'b1;
      end
      BR_JALR: begin
        next_pc = reg_pc_s;
        taken   = 1'b1;
      end
      BR_ILLEGAL: begin
        next_pc = seq_pc_s;
        illegal = 1'b1;
      end
      BR_EQ: begin
        taken   = zero;
        next_pc = zero ? rel_pc_s : seq_pc_s;
      end
      BR_NE: begin
        taken   = ~zero;
        next_pc = zero ? seq_pc_s : rel_pc_s;
      end
      BR_LT: begin
        taken   = less;
        next_pc = less ? rel_pc_s : seq_pc_s;
      end
      BR_GE: begin
        taken   = ~less;
        next_pc = less ? seq_pc_s : rel_pc_s;
      end
      default: begin
        next_pc = seq_pc_s;
        taken   = 1'b0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle next-PC controller: owns the PC, issues fetch requests,
// accepts the returned instruction, waits for execute resolution and
// commits the next PC with retire/taken accounting.
import npc_pkg::*;

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_sequencer_if.master       bus,
  input  logic                 exe_valid,
  input  logic [2:0]           branch,
  input  logic                 less,
  input  logic                 zero,
  input  logic [31:0]          imm,
  input  logic [31:0]          rs1,
  input  logic                 halt,
  output logic [31:0]          pc,
  output logic                 commit,
  output logic                 taken,
  output logic                 illegal,
  output logic                 halted,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [CNT_W-1:0]     taken_cnt
);

  seq_state_t  state_r;
  logic        fetch_valid_r;
  logic        inst_ready_r;
  logic [31:0] br_next_pc_s;
  logic        br_taken_s;
  logic        br_illegal_s;

  // The fetch address is the PC register itself, so it cannot move while a
  // request is pending (PC only changes on a commit edge).
  assign bus.fetch_valid = fetch_valid_r;
  assign bus.fetch_addr  = pc;
  assign bus.inst_ready  = inst_ready_r;

  branch_resolve u_branch_resolve (
    .branch  (branch),
    .less    (less),
    .zero    (zero),
    .pc      (pc),
    .imm     (imm),
    .rs1     (rs1),
    .next_pc (br_next_pc_s),
    .taken   (br_taken_s),
    .illegal (br_illegal_s)
  );

  // Sequencer FSM with registered handshake, commit and counter outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_FETCH;
      pc            <= RESET_PC;
      fetch_valid_r <= 1'b0;
      inst_ready_r  <= 1'b0;
      commit        <= 1'b0;
      taken         <= 1'b0;
      illegal       <= 1'b0;
      halted        <= 1'b0;
      retire_cnt    <= {CNT_W{1'b0}};
      taken_cnt     <= {CNT_W{1'b0}};
    end else begin
      // commit qualifiers are single-cycle pulses
      commit  <= 1'b0;
      taken   <= 1'b0;
      illegal <= 1'b0;
      case (state_r)
        ST_FETCH: begin
          if (fetch_valid_r && bus.fetch_ready) begin
            fetch_valid_r <= 1'b0;
            inst_ready_r  <= 1'b1;
            state_r       <= ST_WAIT_INST;
          end else begin
            // raises the request in the first cycle after reset, then holds it
            fetch_valid_r <= 1'b1;
          end
        end
        ST_WAIT_INST: begin
          if (bus.inst_valid) begin
            inst_ready_r <= 1'b0;
            state_r      <= ST_EXEC;
          end else begin
            inst_ready_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (exe_valid) begin
            pc         <= br_next_pc_s;
            commit     <= 1'b1;
            taken      <= br_taken_s;
            illegal    <= br_illegal_s;
            retire_cnt <= retire_cnt + CNT_W'(1);
            taken_cnt  <= taken_cnt + CNT_W'(br_taken_s);
            if (halt) begin
              halted        <= 1'b1;
              fetch_valid_r <= 1'b0;
              state_r       <= ST_HALT;
            end else begin
              fetch_valid_r <= 1'b1;
              state_r       <= ST_FETCH;
            end
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_HALT: begin
          fetch_valid_r <= 1'b0;
          inst_ready_r  <= 1'b0;
          state_r       <= ST_HALT;
        end
        default: begin
          fetch_valid_r <= 1'b0;
          inst_ready_r  <= 1'b0;
          state_r       <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// instruction streams compared against an instruction-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exe_valid = 1'b0;
  logic [2:0]  branch = 3'b000;
  logic        less = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] imm = 32'h0;
  logic [31:0] rs1 = 32'h0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic        commit, taken, illegal, halted;
  logic [31:0] retire_cnt, taken_cnt;

  pc_sequencer_if ifc ();

  pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc.master),
    .exe_valid  (exe_valid),
    .branch     (branch),
    .less       (less),
    .zero       (zero),
    .imm        (imm),
    .rs1        (rs1),
    .halt       (halt),
    .pc         (pc),
    .commit     (commit),
    .taken      (taken),
    .illegal    (illegal),
    .halted     (halted),
    .retire_cnt (retire_cnt),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_pc;
  int unsigned m_retire;
  int unsigned m_taken;
  logic        m_halted;
  int          last_commit_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level rule: what the PC becomes after one resolved instruction
  function automatic logic [31:0] model_next(input logic [2:0] br, input logic l, input logic z,
                                             input logic [31:0] p, input logic [31:0] i,
                                             input logic [31:0] r, output logic tk, output logic il);
    logic [31:0] tgt;
    tk = 1'b0;
    il = 1'b0;
    tgt = p + 32'd4;
    if (br == 3'd1) begin
      tk = 1'b1;
      tgt = p + i;
    end else if (br == 3'd2) begin
      tk = 1'b1;
      tgt = (r + i) & 32'hFFFF_FFFE;
    end else if (br == 3'd3) begin
      il = 1'b1;
    end else if (br == 3'd4 && z) begin
      tk = 1'b1;
    end else if (br == 3'd5 && !z) begin
      tk = 1'b1;
    end else if (br == 3'd6 && l) begin
      tk = 1'b1;
    end else if (br == 3'd7 && !l) begin
      tk = 1'b1;
    end
    if (tk && br >= 3'd4) tgt = p + i;
    return tgt;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    exe_valid = 1'b0;
    ifc.fetch_ready = 1'b0;
    ifc.inst_valid = 1'b0;
    halt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_pc = RST_PC;
    m_retire = 0;
    m_taken = 0;
    m_halted = 1'b0;
    check("rst_fetch_valid", 64'(ifc.fetch_valid), 64'd0);
    check("rst_pc", 64'(pc), 64'(RST_PC));
    check("rst_commit", 64'({commit, taken, illegal}), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_cnts", {retire_cnt, taken_cnt}, 64'd0);
  endtask

  // One full instruction: fetch (with optional stall), instruction return,
  // execute (with optional delay) and commit check against the model.
  task automatic run_instr(input logic [2:0] br, input logic l, input logic z,
                           input logic [31:0] i, input logic [31:0] r, input logic h,
                           input int fd, input int ed);
    logic tk, il;
    logic [31:0] exp_pc;
    for (int k = 0; k < 8 && !ifc.fetch_valid; k++) tick();
    check("fetch_valid_up", 64'(ifc.fetch_valid), 64'd1);
    for (int k = 0; k < fd; k++) begin
      tick();
      check("stall_fetch_valid", 64'(ifc.fetch_valid), 64'd1);
      check("stall_fetch_addr", 64'(ifc.fetch_addr), 64'(m_pc));
    end
    check("fetch_addr", 64'(ifc.fetch_addr), 64'(m_pc));
    ifc.fetch_ready = 1'b1;
    tick();
    ifc.fetch_ready = 1'b0;
    check("commit_pulse_end", 64'(commit), 64'd0);
    check("inst_ready", 64'(ifc.inst_ready), 64'd1);
    ifc.inst_valid = 1'b1;
    tick();
    ifc.inst_valid = 1'b0;
    for (int k = 0; k < ed; k++) begin
      tick();
      check("no_early_commit", 64'(commit), 64'd0);
    end
    branch = br; less = l; zero = z; imm = i; rs1 = r; halt = h;
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    halt = 1'b0;
    exp_pc = model_next(br, l, z, m_pc, i, r, tk, il);
    m_pc = exp_pc;
    m_retire++;
    if (tk) m_taken++;
    if (h) m_halted = 1'b1;
    last_commit_cyc = cyc;
    check("commit", 64'(commit), 64'd1);
    check("pc", 64'(pc), 64'(m_pc));
    check("taken", 64'(taken), 64'(tk));
    check("illegal", 64'(illegal), 64'(il));
    check("retire_cnt", 64'(retire_cnt), 64'(m_retire));
    check("taken_cnt", 64'(taken_cnt), 64'(m_taken));
    check("halted", 64'(halted), 64'(m_halted));
  endtask

  initial begin
    int c1, c2, c3;
    logic [2:0] rb;
    logic [31:0] ri;
    ifc.fetch_ready = 1'b0;
    ifc.inst_valid = 1'b0;
    do_reset();
    tick();
    check("post_rst_fetch_valid", 64'(ifc.fetch_valid), 64'd1);

    // back-to-back sequential instructions, 3 cycles each
    run_instr(3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0); c1 = last_commit_cyc;
    run_instr(3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0); c2 = last_commit_cyc;
    run_instr(3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0); c3 = last_commit_cyc;
    check("cpi_1", 64'(c2 - c1), 64'd3);
    check("cpi_2", 64'(c3 - c2), 64'd3);
    check("pc_after_3", 64'(pc), 64'h8000_000C);
    run_instr(3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);

    // beq taken back to 80000000, then beq not taken from 80000010
    run_instr(3'd4, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0, 0, 0);
    check("beq_taken_pc", 64'(pc), 64'h8000_0000);
    for (int k = 0; k < 4; k++) run_instr(3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
    run_instr(3'd4, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, 0, 0);
    check("beq_nt_pc", 64'(pc), 64'h8000_0014);

    // jalr and jal
    run_instr(3'd2, 1'b0, 1'b0, 32'h4, 32'h8000_1003, 1'b0, 0, 0);
    check("jalr_pc", 64'(pc), 64'h8000_1006);
    run_instr(3'd1, 1'b0, 1'b0, 32'h7FC, 32'h0, 1'b0, 0, 0);
    check("jal_pc", 64'(pc), 64'h8000_1802);

    // fetch stall of 5 cycles and execute delay of 4 cycles
    run_instr(3'd6, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 5, 4);

    // illegal code: sequential PC with illegal flag for one cycle
    run_instr(3'd3, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 0, 0);
    tick();
    check("illegal_one_cycle", 64'(illegal), 64'd0);

    // halt together with a jump
    run_instr(3'd1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      ifc.fetch_ready = 1'b1;
      ifc.inst_valid = 1'b1;
      tick();
      check("halt_no_fetch", 64'(ifc.fetch_valid), 64'd0);
      check("halt_pc_frozen", 64'(pc), 64'(m_pc));
      check("halt_sticky", 64'(halted), 64'd1);
      check("halt_no_commit", 64'(commit), 64'd0);
    end
    ifc.fetch_ready = 1'b0;
    ifc.inst_valid = 1'b0;

    // reset while waiting for the instruction; late response is ignored
    do_reset();
    run_instr(3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
    tick();
    ifc.fetch_ready = 1'b1;
    tick();
    ifc.fetch_ready = 1'b0;
    check("wait_inst_ready", 64'(ifc.inst_ready), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pc = RST_PC; m_retire = 0; m_taken = 0; m_halted = 1'b0;
    ifc.inst_valid = 1'b1;
    tick();
    ifc.inst_valid = 1'b0;
    check("midrst_fetch_valid", 64'(ifc.fetch_valid), 64'd1);
    check("midrst_inst_ready", 64'(ifc.inst_ready), 64'd0);
    check("midrst_pc", 64'(pc), 64'(RST_PC));
    check("midrst_cnts", {retire_cnt, taken_cnt}, 64'd0);
    run_instr(3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      rb = 3'($urandom_range(0, 7));
      ri = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) - 32'd128 : 32'($urandom);
      run_instr(rb, 1'($urandom), 1'($urandom), ri, 32'($urandom), 1'b0,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle next-PC controller for the NPC core. It owns the program counter and drives the instruction-fetch request handshake. It waits for the execute stage to report a resolved instruction, then evaluates the 3-bit branch code against the ALU `less`/`zero` flags. It commits the next PC (pc+4, pc+imm, or (rs1+imm)&~1) and replaces the free-running combinational PC update path between the decoder/ALU and the PC register.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset
- `CNT_W`, 32, width of retire/taken counters

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high
- `fetch_valid`  out  1  fetch request for `pc` is pending
- `fetch_ready`  in  1  IFU accepts request
- `inst_valid`  in  1  IFU returns instruction for current `pc`
- `inst_ready`  out  1  sequencer accepts returned instruction
- `exe_valid`  in  1  execute stage has resolved current instruction; branch inputs valid this cycle
- `branch`  in  3  000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu, 011 illegal
- `less`  in  1  ALU less-than flag
- `zero`  in  1  ALU zero flag
- `imm`  in  32  sign-extended immediate
- `rs1`  in  32  rs1 register value
- `halt`  in  1  ebreak seen; sampled with `exe_valid`
- `pc`  out  32  current PC
- `commit`  out  1  one-cycle pulse when PC is updated
- `taken`  out  1  valid with `commit`: PC left sequential path
- `illegal`  out  1  valid with `commit`: branch code 011
- `halted`  out  1  sticky; set on halt commit
- `retire_cnt`  out  CNT_W  committed instructions
- `taken_cnt`  out  CNT_W  committed taken branches/jumps

## Operation
- States: FETCH, WAIT_INST, EXEC, HALT.
- Reset: state FETCH; `pc`=RESET_PC; `commit`/`taken`/`illegal`/`halted`=0; counters=0; `fetch_valid`=0 in the reset cycle, then 1.
- FETCH: `fetch_valid`=1 and `fetch_addr`=`pc` held stable until `fetch_ready`. On `fetch_valid`&`fetch_ready`, go to WAIT_INST.
- WAIT_INST: `inst_ready`=1. On `inst_valid`, go to EXEC. An `inst_valid` arriving in any other state is ignored.
- EXEC: wait for `exe_valid`. When it arrives:
  - Next PC: 000 → pc+4. 001 → pc+imm. 010 → (rs1+imm)&~32'h1.
  - Conditional codes: 100 taken iff zero; 101 iff !zero; 110 iff less; 111 iff !less. Taken → pc+imm, else pc+4.
  - 011 → pc+4 with `illegal`=1.
  - `taken`=1 for 001, 010, and taken conditionals.
  - `pc` updates, `commit` pulses, `retire_cnt`++, `taken_cnt`+=taken. Go to FETCH, or to HALT if `halt`=1.
- HALT: terminal until `rst`. `pc` frozen; `halted`=1; no requests issued.
- Arithmetic: all 32-bit modulo 2^32 with wrap ignored. Counters wrap at 2^CNT_W.

## Timing
- Minimum 3 cycles per instruction: FETCH handshake → WAIT_INST with same-cycle `inst_valid` → EXEC with same-cycle `exe_valid`.
- `pc` changes only on the edge ending a commit cycle. `commit`/`taken`/`illegal` are registered and appear the cycle after the `exe_valid` cycle, lasting exactly 1 cycle.
- `fetch_valid` must not drop before `fetch_ready`. `fetch_addr` must not change while `fetch_valid` is high.
- `halt` and a branch in the same `exe_valid` cycle: PC is still updated and counted, then HALT.
- `rst` mid-operation, in any state: next cycle is the reset state. Pending IFU responses are dropped and counters are cleared.

## Structure
- Shared package `npc_pkg`:
  - branch code constants `BR_NONE`, `BR_JAL`, `BR_JALR`, `BR_EQ`, `BR_NE`, `BR_LT`, `BR_GE`
  - state enum
  - `RESET_PC` default
- Sub-module `branch_resolve`: combinational; inputs branch/less/zero/pc/imm/rs1; outputs next_pc, taken, illegal. The FSM and counters stay in `pc_sequencer`.

## Test plan
- Reset, `fetch_ready`=1, `inst_valid` and `exe_valid` with branch=000 each state → commits at pc 80000000, 80000004, 80000008; `retire_cnt`=3; 3 cycles per commit.
- pc=80000010, branch=100, zero=1, imm=-16 → pc=80000000, `taken`=1. Repeat with zero=0 → pc=80000014, `taken`=0.
- branch=010, rs1=80001003, imm=4 → pc=80001006. Separately, branch=001, imm=0x7FC → pc+0x7FC.
- `fetch_ready` held low 5 cycles → `fetch_valid` stays 1 and `fetch_addr` stays stable. `exe_valid` delayed 4 cycles → no commit until it arrives.
- branch=011 → pc+4, `illegal`=1 for one cycle. `halt`=1 with branch=001 → PC updated, `halted`=1, no further `fetch_valid`.
- `rst` asserted in WAIT_INST, then `inst_valid` → response ignored; pc=RESET_PC; counters=0.
